// File: rtl/wb_arb2_if.sv
// Two-master Wishbone arbiter bus bundle.
// slave: arbiter view; master: masters plus downstream slave.
interface wb_arb2_if;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o, m0_err_o;

  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_adr_i, m1_dat_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o, m1_err_o;

  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i,
    input  m0_adr_i, m0_dat_i, m0_sel_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i,
    input  m1_adr_i, m1_dat_i, m1_sel_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_cyc_o, s_stb_o, s_we_o,
    output s_adr_o, s_dat_o, s_sel_o,
    input  s_dat_i, s_ack_i
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i,
    output m0_adr_i, m0_dat_i, m0_sel_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_cyc_i, m1_stb_i, m1_we_i,
    output m1_adr_i, m1_dat_i, m1_sel_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_cyc_o, s_stb_o, s_we_o,
    input  s_adr_o, s_dat_o, s_sel_o,
    output s_dat_i, s_ack_i
  );
endinterface

// File: rtl/wb_arb2.sv
// Round-robin two-master Wishbone arbiter
// with per-strobe ack timeout.
module wb_arb2 #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic       clk_i,
  input logic       rst_n_i,
  wb_arb2_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [7:0] TO = TIMEOUT[7:0];

  state_t     state, state_nxt;
  logic       last, last_nxt;
  logic [7:0] cnt, cnt_nxt;

  logic req0, req1;
  logic g0, g1, gnt;
  logic cyc_g, stb_g;
  logic tp;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    req0  = bus.m0_cyc_i & bus.m0_stb_i;
    req1  = bus.m1_cyc_i & bus.m1_stb_i;
    g0    = (state == GNT0);
    g1    = (state == GNT1);
    gnt   = g0 | g1;
    cyc_g = 1'b0;
    stb_g = 1'b0;
    unique case (1'b1)
      g0: begin
        cyc_g = bus.m0_cyc_i;
        stb_g = bus.m0_stb_i;
      end
      g1: begin
        cyc_g = bus.m1_cyc_i;
        stb_g = bus.m1_stb_i;
      end
      default: ;
    endcase
    // an ack arriving on the deadline cycle beats the timeout
    tp = gnt & (cnt == TO) & ~bus.s_ack_i;
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    unique case (state)
      IDLE: begin
        if (req0 & req1)
          state_nxt = last ? GNT0 : GNT1;
        else if (req0)
          state_nxt = GNT0;
        else if (req1)
          state_nxt = GNT1;
        else
          state_nxt = IDLE;
        if (state_nxt == GNT0) last_nxt = 1'b0;
        if (state_nxt == GNT1) last_nxt = 1'b1;
      end
      GNT0, GNT1: begin
        if (!cyc_g) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt = 8'd0;
    if (gnt & stb_g & ~bus.s_ack_i & ~tp)
      cnt_nxt = cnt + 8'd1;
  end

  always_comb begin
    bus.s_cyc_o = cyc_g;
    bus.s_stb_o = stb_g & ~tp;
    bus.s_we_o  = 1'b0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    unique case (1'b1)
      g0: begin
        bus.s_we_o  = bus.m0_we_i;
        bus.s_adr_o = bus.m0_adr_i;
        bus.s_dat_o = bus.m0_dat_i;
        bus.s_sel_o = bus.m0_sel_i;
      end
      g1: begin
        bus.s_we_o  = bus.m1_we_i;
        bus.s_adr_o = bus.m1_adr_i;
        bus.s_dat_o = bus.m1_dat_i;
        bus.s_sel_o = bus.m1_sel_i;
      end
      default: ;
    endcase
  end

  assign bus.m0_dat_o = bus.s_dat_i;
  assign bus.m1_dat_o = bus.s_dat_i;
  assign bus.m0_ack_o = g0 & bus.m0_stb_i & bus.s_ack_i;
  assign bus.m1_ack_o = g1 & bus.m1_stb_i & bus.s_ack_i;
  assign bus.m0_err_o = g0 & tp;
  assign bus.m1_err_o = g1 & tp;

endmodule

// File: tb/tb_wb_arb2.sv
// Directed bench for wb_arb2: grants, round-robin,
// timeout, ack race and reset abort.
module tb_wb_arb2;

  localparam logic [31:0] A0 = 32'hA000_0010;
  localparam logic [31:0] B1 = 32'hB100_0020;
  localparam logic [31:0] D0 = 32'h0D0D_0000;
  localparam logic [31:0] D1 = 32'h1D1D_1111;
  localparam logic [31:0] SD = 32'h5A5A_1234;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  wb_arb2_if bus ();

  wb_arb2 #(.TIMEOUT(15)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // {cyc, stb, we, m0_ack, m0_err, m1_ack, m1_err}
  wire [6:0] ctl = {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o,
                    bus.m0_ack_o, bus.m0_err_o,
                    bus.m1_ack_o, bus.m1_err_o};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m0_we_i = 1;
    bus.m0_adr_i = A0; bus.m0_dat_i = D0; bus.m0_sel_i = 4'h3;
    bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.m1_we_i = 0;
    bus.m1_adr_i = B1; bus.m1_dat_i = D1; bus.m1_sel_i = 4'hC;
    bus.s_dat_i = SD; bus.s_ack_i = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_in();
    repeat (2) step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_in();
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
    bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_we_i = 1;
    bus.s_ack_i = 1;
    repeat (3) step();
    n_cmp++;
    if (ctl !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b want %b", ctl, 7'b0);
    end
    n_cmp++;
    if ({bus.s_adr_o, bus.s_dat_o, bus.s_sel_o} !== 68'h0) begin
      n_bad++;
      $display("FAIL reset_bus: got %h/%h/%h want 0",
               bus.s_adr_o, bus.s_dat_o, bus.s_sel_o);
    end
    n_cmp++;
    if (bus.m0_dat_o !== SD || bus.m1_dat_o !== SD) begin
      n_bad++;
      $display("FAIL dat_fanout: got %h/%h want %h",
               bus.m0_dat_o, bus.m1_dat_o, SD);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_we_i = 1;
    #1;
    n_cmp++;
    if (bus.s_adr_o !== 32'h0 || ctl !== 7'b0) begin
      n_bad++;
      $display("FAIL single_c0: got %h %b want 0 0",
               bus.s_adr_o, ctl);
    end
    step();
    #1;
    n_cmp++;
    if ({bus.s_adr_o, bus.s_dat_o, bus.s_sel_o} !==
        {B1, D1, 4'hC} || ctl !== 7'b1110000) begin
      n_bad++;
      $display("FAIL single_c1: got %h %h %h %b want %h %h c 1110000",
               bus.s_adr_o, bus.s_dat_o, bus.s_sel_o, ctl, B1, D1);
    end
    step();
    bus.s_ack_i = 1;
    #1;
    n_cmp++;
    if (ctl !== 7'b1110010) begin
      n_bad++;
      $display("FAIL single_ack: got %b want %b", ctl, 7'b1110010);
    end
    step();
    bus.s_ack_i = 0;
    bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.m1_we_i = 0;
    step();
    #1;
    n_cmp++;
    if (bus.s_adr_o !== 32'h0 || ctl !== 7'b0) begin
      n_bad++;
      $display("FAIL single_idle: got %h %b want 0 0",
               bus.s_adr_o, ctl);
    end
  endtask

  task automatic test_contention();
    logic [31:0] ea [7];
    logic [6:0]  ec [7];
    ea = '{32'h0, A0, A0, A0, A0, 32'h0, B1};
    ec = '{7'b0, 7'b1110000, 7'b1010000, 7'b1111000,
           7'b0010000, 7'b0, 7'b1100000};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c > 0) step();
      bus.m0_cyc_i = (c < 4);
      bus.m0_stb_i = (c < 4) && (c != 2);
      bus.m1_cyc_i = 1; bus.m1_stb_i = 1;
      bus.s_ack_i  = (c == 3);
      #1;
      n_cmp++;
      if (bus.s_adr_o !== ea[c] || ctl !== ec[c]) begin
        n_bad++;
        $display("FAIL contention_c%0d: got %h %b want %h %b",
                 c, bus.s_adr_o, ctl, ea[c], ec[c]);
      end
    end
  endtask

  task automatic test_round_robin();
    int own;
    logic [31:0] ea;
    logic [1:0]  ek;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      if (c > 0) step();
      bus.m0_cyc_i = !(c == 2 || c == 8);
      bus.m0_stb_i = bus.m0_cyc_i;
      bus.m1_cyc_i = !(c == 5 || c == 11);
      bus.m1_stb_i = bus.m1_cyc_i;
      bus.s_ack_i  = (c % 3 == 1);
      own = (c % 3 == 0) ? -1 : (((c / 3) % 2 == 0) ? 0 : 1);
      ea = (own == 0) ? A0 : ((own == 1) ? B1 : 32'h0);
      ek = {(c % 3 == 1) && own == 0, (c % 3 == 1) && own == 1};
      #1;
      n_cmp++;
      if (bus.s_adr_o !== ea ||
          {bus.m0_ack_o, bus.m1_ack_o} !== ek ||
          {bus.m0_err_o, bus.m1_err_o} !== 2'b00) begin
        n_bad++;
        $display("FAIL rr_c%0d: got %h ack%b err%b want %h ack%b err00",
                 c, bus.s_adr_o, {bus.m0_ack_o, bus.m1_ack_o},
                 {bus.m0_err_o, bus.m1_err_o}, ea, ek);
      end
    end
  endtask

  // stb held except at gap_c, ack only at ack_c; err expected at err_c
  task automatic run_wait(input string nm, input int last_c,
                          input int gap_c, input int ack_c,
                          input int err_c);
    logic [3:0] exp;
    do_reset();
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_we_i = 0;
    for (int c = 1; c <= last_c; c++) begin
      step();
      bus.m0_stb_i = (c != gap_c);
      bus.s_ack_i  = (c == ack_c);
      exp = {(c != gap_c) && (c != err_c),
             (c == ack_c), (c == err_c), 1'b0};
      #1;
      n_cmp++;
      if ({bus.s_stb_o, bus.m0_ack_o, bus.m0_err_o,
           bus.m1_err_o} !== exp || bus.s_adr_o !== A0) begin
        n_bad++;
        $display("FAIL %s_c%0d: got stb/ack/err/err1 %b adr %h want %b %h",
                 nm, c, {bus.s_stb_o, bus.m0_ack_o, bus.m0_err_o,
                 bus.m1_err_o}, bus.s_adr_o, exp, A0);
      end
    end
    step();
    bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.s_ack_i = 0;
    step();
    #1;
    n_cmp++;
    if (ctl !== 7'b0 || bus.s_adr_o !== 32'h0) begin
      n_bad++;
      $display("FAIL %s_release: got %b %h want 0 0",
               nm, ctl, bus.s_adr_o);
    end
  endtask

  task automatic test_timeout();
    run_wait("timeout", 17, 0, 0, 16);
  endtask

  task automatic test_ack_race();
    run_wait("race", 20, 0, 16, 0);
  endtask

  task automatic test_stb_gap();
    run_wait("stbgap", 27, 10, 0, 26);
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
    bus.m1_cyc_i = 1; bus.m1_stb_i = 1;
    step();
    bus.s_ack_i = 1;
    #1;
    n_cmp++;
    if (ctl !== 7'b1111000) begin
      n_bad++;
      $display("FAIL rstmid_pre: got %b want %b", ctl, 7'b1111000);
    end
    #1;
    rst_n = 0;
    #1;
    n_cmp++;
    if (ctl !== 7'b0 || bus.s_adr_o !== 32'h0 ||
        bus.s_dat_o !== 32'h0) begin
      n_bad++;
      $display("FAIL rstmid_abort: got %b %h %h want 0 0 0",
               ctl, bus.s_adr_o, bus.s_dat_o);
    end
    step();
    rst_n = 1;
    bus.s_ack_i = 0;
    #1;
    n_cmp++;
    if (bus.s_adr_o !== 32'h0 || ctl !== 7'b0) begin
      n_bad++;
      $display("FAIL rstmid_idle: got %h %b want 0 0",
               bus.s_adr_o, ctl);
    end
    step();
    #1;
    n_cmp++;
    if (bus.s_adr_o !== A0 || ctl !== 7'b1110000) begin
      n_bad++;
      $display("FAIL rstmid_regrant: got %h %b want %h 1110000",
               bus.s_adr_o, ctl, A0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_round_robin();
    test_timeout();
    test_ack_race();
    test_stb_gap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
